// File: rtl/cascade_stage_controller_pkg.sv
// Shared definitions for the Haar cascade stage controller: FSM encoding, stage-table word
// layout, accumulator saturation limits and the compiled-in stage table image.
package cascade_stage_controller_pkg;

   localparam int unsigned StageAddrW = 10;
   localparam int unsigned StageDataW = 16;
   localparam int unsigned StageWordW = 2 * StageAddrW + StageDataW;

   // Stage-table word: {base_addr, classifier_size, stage_threshold}
   localparam int unsigned ThrLsb  = 0;
   localparam int unsigned SizeLsb = ThrLsb + StageDataW;
   localparam int unsigned BaseLsb = SizeLsb + StageAddrW;

   localparam logic [StageDataW-1:0] AccMax = {1'b0, {(StageDataW-1){1'b1}}};
   localparam logic [StageDataW-1:0] AccMin = {1'b1, {(StageDataW-1){1'b0}}};

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StTrig,
      StAccum,
      StDecide,
      StReport
   } state_e;

   // Image of stage_info.mif; regenerate together with the classifier ROM.
   function automatic logic [StageWordW-1:0] stage_table_word(input int unsigned idx);
      logic [StageAddrW-1:0] base;
      logic [StageAddrW-1:0] size;
      logic [StageDataW-1:0] thr;
      case (idx)
         0: begin base = StageAddrW'(0);  size = StageAddrW'(3);  thr = StageDataW'(10);    end
         1: begin base = StageAddrW'(3);  size = StageAddrW'(3);  thr = StageDataW'(0);     end
         2: begin base = StageAddrW'(6);  size = StageAddrW'(20); thr = StageDataW'(32767); end
         3: begin base = StageAddrW'(26); size = StageAddrW'(1);  thr = StageDataW'(7);     end
         4: begin base = StageAddrW'(27); size = StageAddrW'(0);  thr = StageDataW'(0);     end
         default: begin
            base = StageAddrW'(27 + 2 * (idx - 5));
            size = StageAddrW'(2);
            thr  = StageDataW'(0);
         end
      endcase
      return {base, size, thr};
   endfunction

endpackage

// File: rtl/cascade_stage_controller_stage_info_rom.sv
// Synchronous per-stage parameter ROM, one word per cascade stage, 1-cycle read latency.
module cascade_stage_controller_stage_info_rom
   import cascade_stage_controller_pkg::*;
#(
   parameter int unsigned NumStages     = 25,
   parameter int unsigned IdxWidth      = 5,
   parameter string       StageInfoFile = "stage_info.mif"
) (
   input  logic                  clk_fpga,
   input  logic [IdxWidth-1:0]   addr_i,
   output logic [StageWordW-1:0] data_o
);

   // An empty image name yields an all-zero table.
   localparam bit HasImage = (StageInfoFile != "");

   logic [StageWordW-1:0] data_q;

   always_ff @(posedge clk_fpga) begin
      if (HasImage && (32'(addr_i) < NumStages)) begin
         data_q <= stage_table_word(32'(addr_i));
      end else begin
         data_q <= '0;
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/cascade_stage_controller.sv
// Haar cascade initiator: runs every stage of one window, accumulates haar values with
// saturation and reports the verdict. Optional statistics counters under CASCADE_STATS_EN.
module cascade_stage_controller
   import cascade_stage_controller_pkg::*;
#(
   parameter int unsigned NUM_STAGES      = 25,
   parameter int unsigned STAGE_IDX_WIDTH = 5,
   parameter int unsigned ADDR_WIDTH      = StageAddrW,
   parameter int unsigned DATA_WIDTH_12   = 12,
   parameter int unsigned DATA_WIDTH_16   = StageDataW,
   parameter string       STAGE_INFO_FILE = "stage_info.mif"
) (
   input  logic                        clk_fpga,
   input  logic                        reset_fpga,
   input  logic                        i_window_valid,
   output logic                        o_window_ready,
   output logic                        o_trigger_compare_stage,
   output logic [ADDR_WIDTH-1:0]       o_stage_base_address,
   output logic [ADDR_WIDTH-1:0]       o_classifier_size,
   input  logic                        i_haar_valid,
   input  logic signed [DATA_WIDTH_12-1:0] i_haar_value,
   input  logic                        i_is_end_of_stage,
   output logic                        o_result_valid,
   output logic                        o_is_candidate,
   output logic [STAGE_IDX_WIDTH-1:0]  o_reject_stage
`ifdef CASCADE_STATS_EN
   ,
   output logic [DATA_WIDTH_16-1:0]    o_num_windows,
   output logic [DATA_WIDTH_16-1:0]    o_num_candidates
`endif
);

   localparam logic [STAGE_IDX_WIDTH-1:0] LastStage = STAGE_IDX_WIDTH'(NUM_STAGES - 1);

   state_e                      state_q, state_d;
   logic [STAGE_IDX_WIDTH-1:0]  stage_q, stage_d;
   logic [DATA_WIDTH_16-1:0]    acc_q, acc_d;
   logic [ADDR_WIDTH-1:0]       base_q, base_d;
   logic [ADDR_WIDTH-1:0]       size_q, size_d;
   logic [DATA_WIDTH_16-1:0]    thr_q, thr_d;
   logic                        cand_q, cand_d;
   logic [STAGE_IDX_WIDTH-1:0]  reject_q, reject_d;
   logic [StageWordW-1:0]       rom_word;
   logic [DATA_WIDTH_16:0]      sum_wide;
   logic [DATA_WIDTH_16-1:0]    acc_sat;
   logic                        stage_pass;

   // Addressed with the next stage index so the word is ready while in LOAD.
   cascade_stage_controller_stage_info_rom #(
      .NumStages     (NUM_STAGES),
      .IdxWidth      (STAGE_IDX_WIDTH),
      .StageInfoFile (STAGE_INFO_FILE)
   ) u_stage_info_rom (
      .clk_fpga (clk_fpga),
      .addr_i   (stage_d),
      .data_o   (rom_word)
   );

   assign sum_wide = {acc_q[DATA_WIDTH_16-1], acc_q}
                   + {{(DATA_WIDTH_16 + 1 - DATA_WIDTH_12){i_haar_value[DATA_WIDTH_12-1]}},
                      i_haar_value};

   always_comb begin
      acc_sat = sum_wide[DATA_WIDTH_16-1:0];
      if (sum_wide[DATA_WIDTH_16] != sum_wide[DATA_WIDTH_16-1]) begin
         acc_sat = sum_wide[DATA_WIDTH_16] ? AccMin : AccMax;
      end
   end

   assign stage_pass = $signed(acc_q) >= $signed(thr_q);

   always_comb begin
      state_d  = state_q;
      stage_d  = stage_q;
      acc_d    = acc_q;
      base_d   = base_q;
      size_d   = size_q;
      thr_d    = thr_q;
      cand_d   = cand_q;
      reject_d = reject_q;
      unique case (state_q)
         StIdle: begin
            stage_d = '0;
            if (i_window_valid) begin
               state_d = StLoad;
            end
         end
         StLoad: begin
            acc_d   = '0;
            base_d  = rom_word[BaseLsb +: ADDR_WIDTH];
            size_d  = rom_word[SizeLsb +: ADDR_WIDTH];
            thr_d   = rom_word[ThrLsb +: DATA_WIDTH_16];
            state_d = (rom_word[SizeLsb +: ADDR_WIDTH] == '0) ? StDecide : StTrig;
         end
         StTrig: begin
            state_d = StAccum;
         end
         StAccum: begin
            if (i_haar_valid) begin
               acc_d = acc_sat;
            end
            if (i_is_end_of_stage) begin
               state_d = StDecide;
            end
         end
         StDecide: begin
            if (!stage_pass) begin
               state_d  = StReport;
               cand_d   = 1'b0;
               reject_d = stage_q;
            end else if (stage_q == LastStage) begin
               state_d  = StReport;
               cand_d   = 1'b1;
               reject_d = stage_q;
            end else begin
               stage_d = stage_q + STAGE_IDX_WIDTH'(1);
               state_d = StLoad;
            end
         end
         StReport: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_fpga) begin
      if (!reset_fpga) begin
         state_q  <= StIdle;
         stage_q  <= '0;
         acc_q    <= '0;
         base_q   <= '0;
         size_q   <= '0;
         thr_q    <= '0;
         cand_q   <= 1'b0;
         reject_q <= '0;
      end else begin
         state_q  <= state_d;
         stage_q  <= stage_d;
         acc_q    <= acc_d;
         base_q   <= base_d;
         size_q   <= size_d;
         thr_q    <= thr_d;
         cand_q   <= cand_d;
         reject_q <= reject_d;
      end
   end

   assign o_window_ready          = (state_q == StIdle);
   assign o_trigger_compare_stage = (state_q == StTrig);
   assign o_result_valid          = (state_q == StReport);
   assign o_stage_base_address    = base_q;
   assign o_classifier_size       = size_q;
   assign o_is_candidate          = cand_q;
   assign o_reject_stage          = reject_q;

`ifdef CASCADE_STATS_EN
   logic [DATA_WIDTH_16-1:0] num_windows_q;
   logic [DATA_WIDTH_16-1:0] num_candidates_q;

   always_ff @(posedge clk_fpga) begin
      if (!reset_fpga) begin
         num_windows_q    <= '0;
         num_candidates_q <= '0;
      end else if (state_q == StReport) begin
         num_windows_q <= num_windows_q + DATA_WIDTH_16'(1);
         if (cand_q) begin
            num_candidates_q <= num_candidates_q + DATA_WIDTH_16'(1);
         end
      end
   end

   assign o_num_windows    = num_windows_q;
   assign o_num_candidates = num_candidates_q;
`endif

endmodule

// File: tb/tb_cascade_stage_controller.sv
// Directed bench for cascade_stage_controller against the compiled-in stage table.
// Build with CASCADE_STATS_EN defined to also cover the statistics counters.
module tb_cascade_stage_controller;

   logic        clk_fpga;
   logic        reset_fpga;
   logic        i_window_valid;
   logic        o_window_ready;
   logic        o_trigger_compare_stage;
   logic [9:0]  o_stage_base_address;
   logic [9:0]  o_classifier_size;
   logic        i_haar_valid;
   logic [11:0] i_haar_value;
   logic        i_is_end_of_stage;
   logic        o_result_valid;
   logic        o_is_candidate;
   logic [4:0]  o_reject_stage;
`ifdef CASCADE_STATS_EN
   logic [15:0] o_num_windows;
   logic [15:0] o_num_candidates;
`endif

   int checks = 0;
   int errors = 0;
   int trig_cnt = 0;
   int res_cnt = 0;

   cascade_stage_controller dut (
      .clk_fpga                (clk_fpga),
      .reset_fpga              (reset_fpga),
      .i_window_valid          (i_window_valid),
      .o_window_ready          (o_window_ready),
      .o_trigger_compare_stage (o_trigger_compare_stage),
      .o_stage_base_address    (o_stage_base_address),
      .o_classifier_size       (o_classifier_size),
      .i_haar_valid            (i_haar_valid),
      .i_haar_value            (i_haar_value),
      .i_is_end_of_stage       (i_is_end_of_stage),
      .o_result_valid          (o_result_valid),
      .o_is_candidate          (o_is_candidate),
      .o_reject_stage          (o_reject_stage)
`ifdef CASCADE_STATS_EN
      ,
      .o_num_windows           (o_num_windows),
      .o_num_candidates        (o_num_candidates)
`endif
   );

   initial clk_fpga = 1'b0;
   always #5 clk_fpga = ~clk_fpga;

   always @(negedge clk_fpga) begin
      if (o_trigger_compare_stage) trig_cnt++;
      if (o_result_valid) res_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Leaves the bench at the first negedge after acceptance (controller in LOAD).
   task automatic start_window(input string tag);
      i_window_valid = 1'b1;
      @(negedge clk_fpga);
      check_eq({tag, " busy ready"}, o_window_ready, 0);
      i_window_valid = 1'b0;
   endtask

   // Waits for the trigger, then streams n values; ends at the negedge in DECIDE.
   task automatic run_stage(input string tag, input int exp_base, input int exp_size,
                            input int n, input int v0, input int v1, input int v2,
                            input int vr, input bit coincide, output int waited);
      int v;
      waited = 0;
      while (!o_trigger_compare_stage && waited < 8) begin
         @(negedge clk_fpga);
         waited++;
      end
      check_eq({tag, " trig"}, o_trigger_compare_stage, 1);
      check_eq({tag, " base"}, o_stage_base_address, exp_base);
      check_eq({tag, " size"}, o_classifier_size, exp_size);
      @(negedge clk_fpga);
      for (int i = 0; i < n; i++) begin
         v = (i == 0) ? v0 : (i == 1) ? v1 : (i == 2) ? v2 : vr;
         i_haar_valid      = 1'b1;
         i_haar_value      = 12'(v);
         i_is_end_of_stage = coincide && (i == n - 1);
         @(negedge clk_fpga);
      end
      if (!coincide) begin
         i_haar_valid      = 1'b0;
         i_is_end_of_stage = 1'b1;
         @(negedge clk_fpga);
      end
      i_haar_valid      = 1'b0;
      i_is_end_of_stage = 1'b0;
   endtask

   task automatic expect_result(input string tag, input int cand, input int rej);
      int waited = 0;
      while (!o_result_valid && waited < 6) begin
         @(negedge clk_fpga);
         waited++;
      end
      check_eq({tag, " result_valid"}, o_result_valid, 1);
      check_eq({tag, " candidate"}, o_is_candidate, cand);
      check_eq({tag, " reject_stage"}, o_reject_stage, rej);
      @(negedge clk_fpga);
      check_eq({tag, " pulse width"}, o_result_valid, 0);
      check_eq({tag, " ready after"}, o_window_ready, 1);
      check_eq({tag, " candidate held"}, o_is_candidate, cand);
   endtask

   initial begin
      int w;
      int tc0;
      int rc0;
      reset_fpga        = 1'b0;
      i_window_valid    = 1'b0;
      i_haar_valid      = 1'b0;
      i_haar_value      = '0;
      i_is_end_of_stage = 1'b0;
      repeat (3) @(negedge clk_fpga);

      check_eq("reset ready", o_window_ready, 1);
      check_eq("reset trig", o_trigger_compare_stage, 0);
      check_eq("reset result_valid", o_result_valid, 0);
      check_eq("reset candidate", o_is_candidate, 0);
      check_eq("reset reject", o_reject_stage, 0);
      check_eq("reset base", o_stage_base_address, 0);
      check_eq("reset size", o_classifier_size, 0);
`ifdef CASCADE_STATS_EN
      check_eq("reset windows", o_num_windows, 0);
      check_eq("reset candidates", o_num_candidates, 0);
`endif
      reset_fpga = 1'b1;
      // Stray handshake strobes in IDLE must not start anything.
      i_haar_valid = 1'b1;
      i_is_end_of_stage = 1'b1;
      @(negedge clk_fpga);
      i_haar_valid = 1'b0;
      i_is_end_of_stage = 1'b0;
      check_eq("idle ignores haar", o_window_ready, 1);

      // Window B: stage 0 passes (11 >= 10), stage 1 fails (-9 < 0).
      start_window("B");
      run_stage("B s0", 0, 3, 3, 5, 4, 2, 0, 1'b0, w);
      check_eq("B accept->trig latency", w, 1);
      run_stage("B s1", 3, 3, 3, -3, -3, -3, 0, 1'b0, w);
      check_eq("B decide->trig latency", w, 2);
      expect_result("B", 0, 1);

      // Window D: -2048 x20 saturates at -32768 and fails threshold 0 (a wrap would pass).
      start_window("D");
      run_stage("D s0", 0, 3, 3, 5, 4, 2, 0, 1'b0, w);
      run_stage("D s1", 3, 3, 20, -2048, -2048, -2048, -2048, 1'b0, w);
      expect_result("D", 0, 1);

      // Window F: rejected at the first stage.
      start_window("F");
      run_stage("F s0", 0, 3, 3, 0, 0, 0, 0, 1'b0, w);
      expect_result("F", 0, 0);

      // Window C: every stage passes; stage 4 has no classifiers and no trigger.
      tc0 = trig_cnt;
      rc0 = res_cnt;
      start_window("C");
      run_stage("C s0", 0, 3, 3, 5, 4, 2, 0, 1'b0, w);
      run_stage("C s1", 3, 3, 3, 1, 1, 1, 1, 1'b0, w);
      run_stage("C s2", 6, 20, 20, 2047, 2047, 2047, 2047, 1'b0, w);
      run_stage("C s3", 26, 1, 1, 7, 0, 0, 0, 1'b1, w);
      run_stage("C s5", 27, 2, 2, 1, 1, 1, 1, 1'b0, w);
      check_eq("C size0 skip latency", w, 4);
      check_eq("C size0 no trigger", trig_cnt - tc0, 5);
      for (int s = 6; s < 25; s++) begin
         run_stage($sformatf("C s%0d", s), 27 + 2 * (s - 5), 2, 2, 1, 1, 1, 1, 1'b0, w);
      end
      expect_result("C", 1, 24);
      @(negedge clk_fpga);
      check_eq("C trigger pulses", trig_cnt - tc0, 24);
      check_eq("C result pulses", res_cnt - rc0, 1);
`ifdef CASCADE_STATS_EN
      check_eq("stats windows", o_num_windows, 4);
      check_eq("stats candidates", o_num_candidates, 1);
`endif

      // Window E: reset while accumulating stage 3 aborts without a verdict.
      rc0 = res_cnt;
      start_window("E");
      run_stage("E s0", 0, 3, 3, 5, 4, 2, 0, 1'b0, w);
      run_stage("E s1", 3, 3, 3, 1, 1, 1, 1, 1'b0, w);
      run_stage("E s2", 6, 20, 20, 2047, 2047, 2047, 2047, 1'b0, w);
      w = 0;
      while (!o_trigger_compare_stage && w < 8) begin
         @(negedge clk_fpga);
         w++;
      end
      check_eq("E s3 trig", o_trigger_compare_stage, 1);
      @(negedge clk_fpga);
      i_haar_valid = 1'b1;
      i_haar_value = 12'd1;
      @(negedge clk_fpga);
      i_haar_valid = 1'b0;
      reset_fpga = 1'b0;
      @(negedge clk_fpga);
      check_eq("E abort ready", o_window_ready, 1);
      check_eq("E abort result_valid", o_result_valid, 0);
      check_eq("E abort candidate", o_is_candidate, 0);
      check_eq("E abort reject", o_reject_stage, 0);
`ifdef CASCADE_STATS_EN
      check_eq("E reset windows", o_num_windows, 0);
      check_eq("E reset candidates", o_num_candidates, 0);
`endif
      reset_fpga = 1'b1;
      repeat (3) @(negedge clk_fpga);
      check_eq("E no result pulse", res_cnt - rc0, 0);
      check_eq("E idle ready", o_window_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
